// File: rtl/inst_buffer_if.sv
// Fetch/Dispatch-facing bundle of the instruction buffer.
// Packets are opaque PKT_W-bit words; slot 0 is always the oldest.
interface inst_buffer_if #(
  parameter int N     = 2,
  parameter int DEPTH = 16,
  parameter int PKT_W = 64
);
  localparam int SB_W     = $clog2(N + 1);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  // Push handshake: inst_valid may never exceed the inst_buffer_spots
  // advertised in the same cycle. Pop handshake: whatever dispatch_valid
  // shows is consumed at the next rising edge, with no separate ack.
  logic                       restore_valid;
  logic [SB_W-1:0]            inst_valid;
  logic [N-1:0][PKT_W-1:0]    inst_buffer_inputs;
  logic [SB_W-1:0]            inst_buffer_spots;
  logic [SB_W-1:0]            dispatch_spots;
  logic [N-1:0][PKT_W-1:0]    dispatch_packets;
  logic [SB_W-1:0]            dispatch_valid;
  logic [CNT_BITS-1:0]        count_out;

  modport master (
    output restore_valid, inst_valid, inst_buffer_inputs, dispatch_spots,
    input  inst_buffer_spots, dispatch_packets, dispatch_valid, count_out
  );

  modport slave (
    input  restore_valid, inst_valid, inst_buffer_inputs, dispatch_spots,
    output inst_buffer_spots, dispatch_packets, dispatch_valid, count_out
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular FIFO between Fetch and Dispatch: up to N pushes and N show-ahead
// pops per cycle, flushed completely on a branch-stack restore.
module inst_buffer #(
  parameter int N     = 2,
  parameter int DEPTH = 16,
  parameter int PKT_W = 64
) (
  input logic          clock,
  input logic          reset,
  inst_buffer_if.slave bus
);
  localparam int SB_W     = $clog2(N + 1);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] N_C     = CNT_BITS'(N);
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  logic [PKT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  logic [CNT_BITS-1:0] free_c;
  logic [CNT_BITS-1:0] spots_c;
  logic [CNT_BITS-1:0] want_pop_c;
  logic [CNT_BITS-1:0] pop_c;
  logic [CNT_BITS-1:0] want_push_c;
  logic [CNT_BITS-1:0] push_c;

  // Credit to Fetch depends on registered occupancy only, so same-cycle pops
  // never loop back into the push decision.
  always_comb begin
    free_c  = DEPTH_C - count_q;
    spots_c = (free_c < N_C) ? free_c : N_C;
  end

  always_comb begin
    want_pop_c = CNT_BITS'(bus.dispatch_spots);
    if (want_pop_c > N_C) want_pop_c = N_C;
    pop_c = (count_q < want_pop_c) ? count_q : want_pop_c;
    if (bus.restore_valid) pop_c = '0;

    // An illegal over-push is clamped; the excess high slots are dropped.
    want_push_c = CNT_BITS'(bus.inst_valid);
    push_c      = (want_push_c < spots_c) ? want_push_c : spots_c;
    if (bus.restore_valid) push_c = '0;
  end

  always_comb begin
    bus.dispatch_packets = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_BITS'(i) < pop_c) begin
        bus.dispatch_packets[i] = mem_q[head_q + PTR_W'(i)];
      end
    end
  end

  assign bus.dispatch_valid    = SB_W'(pop_c);
  assign bus.inst_buffer_spots = SB_W'(spots_c);
  assign bus.count_out         = count_q;

  always_comb begin
    head_d  = head_q + PTR_W'(pop_c);
    tail_d  = tail_q + PTR_W'(push_c);
    count_d = count_q + push_c - pop_c;
    if (bus.restore_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (CNT_BITS'(i) < push_c) begin
        mem_q[tail_q + PTR_W'(i)] <= bus.inst_buffer_inputs[i];
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      if (!bus.restore_valid) begin
        assert (CNT_BITS'(bus.inst_valid) <= spots_c);
      end
      assert (count_q <= DEPTH_C);
      assert ((count_q == DEPTH_C) ||
              (CNT_BITS'(PTR_W'(tail_q - head_q)) == count_q));
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with N=2, DEPTH=8 and the packet word
// holding its PC; an expected-order queue is checked on every pop.
module tb_inst_buffer;
  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int PKT_W = 32;

  logic clock;
  logic reset;

  inst_buffer_if #(.N(N), .DEPTH(DEPTH), .PKT_W(PKT_W)) bif ();

  inst_buffer #(.N(N), .DEPTH(DEPTH), .PKT_W(PKT_W)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  int total;
  int bad;
  int n_popped;
  logic [PKT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (i < int'(bif.dispatch_valid)) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: slot %0d got 0x%0h, expected queue empty", i,
                     bif.dispatch_packets[i]);
          end else begin
            chk("pop_order", bif.dispatch_packets[i], exp_q.pop_front());
            n_popped++;
          end
        end else begin
          chk("idle_slot_zero", bif.dispatch_packets[i], 32'h0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rv, input int iv, input logic [31:0] p0,
                       input logic [31:0] p1, input int ds);
    logic [31:0] pcs[2];
    pcs[0] = p0;
    pcs[1] = p1;
    bif.restore_valid         = rv;
    bif.inst_valid            = 2'(iv);
    bif.inst_buffer_inputs[0] = p0;
    bif.inst_buffer_inputs[1] = p1;
    bif.dispatch_spots        = 2'(ds);
    if (rv) exp_q.delete();
    else for (int i = 0; i < iv; i++) exp_q.push_back(pcs[i]);
  endtask

  task automatic idle(input int ds);
    drive(1'b0, 0, 32'hdead_0000, 32'hdead_0004, ds);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total    = 0;
    bad      = 0;
    n_popped = 0;
    reset    = 1'b0;
    idle(0);
    #12;
    chk("rst_count", 32'(bif.count_out), 32'd0);
    chk("rst_dvalid", 32'(bif.dispatch_valid), 32'd0);
    chk("rst_spots", 32'(bif.inst_buffer_spots), 32'd2);
    chk("rst_pkts", 32'(bif.dispatch_packets), 32'd0);
    reset = 1'b1;
    tick();

    // Fill with 2/cycle, no dispatch
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2, 32'(8 * k), 32'(8 * k + 4), 0);
      tick();
      chk("fill_count", 32'(bif.count_out), 32'(2 * (k + 1)));
      chk("fill_spots", 32'(bif.inst_buffer_spots), (k == 3) ? 32'd0 : 32'd2);
    end
    idle(0);
    #1;
    chk("full_no_pop", 32'(bif.dispatch_valid), 32'd0);
    tick();
    chk("full_hold_count", 32'(bif.count_out), 32'd8);
    chk("full_hold_spots", 32'(bif.inst_buffer_spots), 32'd0);

    // Drain two from full
    idle(2);
    #1;
    chk("full_dvalid", 32'(bif.dispatch_valid), 32'd2);
    chk("full_pkt0", bif.dispatch_packets[0], 32'h0);
    chk("full_pkt1", bif.dispatch_packets[1], 32'h4);
    tick();
    chk("drain_count", 32'(bif.count_out), 32'd6);
    chk("drain_spots", 32'(bif.inst_buffer_spots), 32'd2);

    // Bring head to 6 (count 2), then steady push 2 / pop 2 across the wrap
    idle(2);
    tick();
    idle(2);
    tick();
    chk("pre_steady_count", 32'(bif.count_out), 32'd2);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 2, 32'h20 + 32'(8 * k), 32'h24 + 32'(8 * k), 2);
      #1;
      chk("steady_dvalid", 32'(bif.dispatch_valid), 32'd2);
      tick();
      chk("steady_count", 32'(bif.count_out), 32'd2);
    end

    // Flush with push and dispatch requested at count 5
    drive(1'b0, 2, 32'h100, 32'h104, 0);
    tick();
    drive(1'b0, 1, 32'h108, 32'h0, 0);
    tick();
    chk("preflush_count", 32'(bif.count_out), 32'd5);
    drive(1'b1, 2, 32'h200, 32'h204, 2);
    #1;
    chk("flush_dvalid", 32'(bif.dispatch_valid), 32'd0);
    tick();
    chk("flush_count", 32'(bif.count_out), 32'd0);
    chk("flush_spots", 32'(bif.inst_buffer_spots), 32'd2);
    idle(2);
    #1;
    chk("flush_no_leftover", 32'(bif.dispatch_valid), 32'd0);
    tick();

    // Empty + push one: visible only the following cycle
    drive(1'b0, 1, 32'h40, 32'h0, 2);
    #1;
    chk("lat_same_cycle", 32'(bif.dispatch_valid), 32'd0);
    tick();
    idle(2);
    #1;
    chk("lat_next_dvalid", 32'(bif.dispatch_valid), 32'd1);
    chk("lat_next_pkt0", bif.dispatch_packets[0], 32'h40);
    tick();
    chk("lat_after_count", 32'(bif.count_out), 32'd0);

    // Asynchronous reset with count 5
    drive(1'b0, 2, 32'h300, 32'h304, 0);
    tick();
    drive(1'b0, 2, 32'h308, 32'h30c, 0);
    tick();
    drive(1'b0, 1, 32'h310, 32'h0, 0);
    tick();
    chk("prerst_count", 32'(bif.count_out), 32'd5);
    idle(2);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_count", 32'(bif.count_out), 32'd0);
    chk("async_rst_dvalid", 32'(bif.dispatch_valid), 32'd0);
    #5;
    reset = 1'b1;
    idle(0);
    tick();
    chk("postrst_spots", 32'(bif.inst_buffer_spots), 32'd2);
    chk("postrst_count", 32'(bif.count_out), 32'd0);
    drive(1'b0, 2, 32'h80, 32'h84, 0);
    tick();
    chk("postrst_push_count", 32'(bif.count_out), 32'd2);
    idle(2);
    tick();
    chk("postrst_drain_count", 32'(bif.count_out), 32'd0);
    idle(0);
    tick();

    chk("total_pops", 32'(n_popped), 32'd29);
    chk("model_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
